// File: rtl/clk_div_cfg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl_pkg
//   Shared definitions for the clock-divider configuration controller:
//   FSM state encoding, default parameter values and a small state decode
//   helper. The default ratio and guard constants are also meant to be
//   imported by divider-level testbenches so both sides agree on them.
// ---------------------------------------------------------------------------
package clk_div_cfg_ctrl_pkg;

  localparam int         RATIO_WD_C      = 8;
  localparam int         GUARD_CYCLES_C  = 4;
  localparam logic [7:0] DEFAULT_RATIO_C = 8'd1;
  localparam logic [7:0] MAX_RATIO_C     = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_QUIESCE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SETTLE  = 3'd4
  } cfg_state_e;

  // Requests are only accepted while the divider is in a steady state.
  function automatic logic is_ready_state(cfg_state_e s);
    return (s == ST_IDLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_cfg_guard_timer.sv
// ---------------------------------------------------------------------------
// cfg_guard_timer
//   Guard-period timer shared by the QUIESCE and SETTLE phases. The counter
//   is cleared on every state entry and counts cycles spent in the state,
//   saturating at GUARD_CYCLES (no wrap). done is high during the
//   GUARD_CYCLES-th cycle after a clear, so a state that leaves on done
//   lasts exactly GUARD_CYCLES cycles.
// Ports
//   clk    in  1  clock, posedge
//   rst    in  1  synchronous active-high reset
//   clear  in  1  restart the count on the next cycle
//   done   out 1  terminal-count pulse
// ---------------------------------------------------------------------------
module cfg_guard_timer #(
  parameter int GUARD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam int             CW   = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0]  TOP  = CW'(GUARD_CYCLES);

  logic [CW-1:0] count;

  // Count up after each clear and park at GUARD_CYCLES so a long stay in a
  // non-guard state never wraps back into a spurious terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count != TOP) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl
//   Configuration stage in front of the integer clock divider. Ratio-change
//   requests arrive over a valid/ready handshake. A change while running
//   drops the divider enable, waits a guard period, loads the new ratio,
//   waits a second guard period and only then re-enables, so the divided
//   clock never produces runt or merged pulses. All outputs are registered.
//
//   Optional feature macro: CFG_RATIO_CHECK_EN
//     defined   : ratio 0 or ratio > MAX_RATIO is handshaken but discarded,
//                 and sets the sticky o_cfg_err flag (cleared by i_err_clr).
//     undefined : every ratio is accepted; o_cfg_err stays 0.
//
// Ports
//   i_ref_clk    in   1         reference clock, posedge
//   i_rst_en     in   1         synchronous active-high reset
//   i_enable     in   1         divided-clock enable request
//   i_req_valid  in   1         ratio-change request valid
//   i_req_ratio  in   RATIO_WD  requested ratio
//   o_req_ready  out  1         request taken when valid & ready at posedge
//   o_div_ratio  out  RATIO_WD  ratio to the divider
//   o_clk_en     out  1         enable to the divider
//   o_busy       out  1         ratio change in progress
//   i_err_clr    in   1         clears o_cfg_err
//   o_cfg_err    out  1         sticky illegal-request flag
// ---------------------------------------------------------------------------
module clk_div_cfg_ctrl
  import clk_div_cfg_ctrl_pkg::*;
#(
  parameter int                  RATIO_WD      = RATIO_WD_C,
  parameter int                  GUARD_CYCLES  = GUARD_CYCLES_C,
  parameter logic [RATIO_WD-1:0] DEFAULT_RATIO = RATIO_WD'(DEFAULT_RATIO_C),
  parameter logic [RATIO_WD-1:0] MAX_RATIO     = RATIO_WD'(MAX_RATIO_C)
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_en,
  input  logic                i_enable,
  input  logic                i_req_valid,
  input  logic [RATIO_WD-1:0] i_req_ratio,
  output logic                o_req_ready,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy,
  input  logic                i_err_clr,
  output logic                o_cfg_err
);

  cfg_state_e          state;
  cfg_state_e          state_next;
  logic [RATIO_WD-1:0] pending;
  logic [RATIO_WD-1:0] pending_next;
  logic [RATIO_WD-1:0] ratio_next;
  logic                clk_en_next;
  logic                ready_next;
  logic                busy_next;
  logic                err_next;
  logic                accept;
  logic                legal;
  logic                guard_clear;
  logic                guard_done;

  assign accept = i_req_valid && o_req_ready;

`ifdef CFG_RATIO_CHECK_EN
  assign legal = (i_req_ratio != '0) && (i_req_ratio <= MAX_RATIO);

  // An illegal request in the same cycle as a clear wins, so the flag
  // cannot be lost by a clear that races a fresh error.
  always_comb begin
    err_next = o_cfg_err;
    if (i_err_clr) begin
      err_next = 1'b0;
    end
    if (accept && !legal) begin
      err_next = 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign legal      = 1'b1;
  assign err_next   = 1'b0;
  assign unused_cfg = ^{i_err_clr, MAX_RATIO};
`endif

  // One timer serves both guard phases; it restarts on every state change.
  assign guard_clear = (state_next != state);

  cfg_guard_timer #(
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_guard_timer (
    .clk   (i_ref_clk),
    .rst   (i_rst_en),
    .clear (guard_clear),
    .done  (guard_done)
  );

  // Next-state and next-output decode. Outputs are computed for the state
  // being entered and registered alongside it. An illegal request is
  // swallowed without any state or ratio change.
  always_comb begin
    state_next   = state;
    ratio_next   = o_div_ratio;
    pending_next = pending;
    clk_en_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        // A request takes priority over enable; RUN follows a cycle later
        // if enable is still high.
        if (accept) begin
          if (legal) begin
            ratio_next = i_req_ratio;
          end
        end else if (i_enable) begin
          state_next  = ST_RUN;
          clk_en_next = 1'b1;
        end
      end

      ST_RUN: begin
        clk_en_next = 1'b1;
        if (accept) begin
          if (legal) begin
            if (!i_enable) begin
              // Divider is stopping anyway, so the ratio can load directly.
              ratio_next  = i_req_ratio;
              state_next  = ST_IDLE;
              clk_en_next = 1'b0;
            end else if (i_req_ratio != o_div_ratio) begin
              pending_next = i_req_ratio;
              state_next   = ST_QUIESCE;
              clk_en_next  = 1'b0;
            end
          end
        end else if (!i_enable) begin
          state_next  = ST_IDLE;
          clk_en_next = 1'b0;
        end
      end

      ST_QUIESCE: begin
        if (guard_done) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ratio_next = pending;
        state_next = ST_SETTLE;
      end

      ST_SETTLE: begin
        // i_enable is only looked at here, after both guard periods.
        if (guard_done) begin
          if (i_enable) begin
            state_next  = ST_RUN;
            clk_en_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ready_next = is_ready_state(state_next);
    busy_next  = !ready_next;
  end

  // State and output registers; reset abandons any change in flight and
  // drops the pending ratio.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst_en) begin
      state       <= ST_IDLE;
      pending     <= DEFAULT_RATIO;
      o_div_ratio <= DEFAULT_RATIO;
      o_clk_en    <= 1'b0;
      o_req_ready <= 1'b1;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      o_div_ratio <= ratio_next;
      o_clk_en    <= clk_en_next;
      o_req_ready <= ready_next;
      o_busy      <= busy_next;
      o_cfg_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_cfg_ctrl
//   Directed bench for clk_div_cfg_ctrl (default parameters, G=4). Stimulus
//   pushes cycle-tagged expected values into a scoreboard queue; a monitor
//   on the falling edge pops every entry due in the current cycle and
//   compares it with the DUT outputs. cyc counts rising edges, so an input
//   driven at the falling edge where cyc==n is sampled by edge n+1 and its
//   effect is visible from cyc==n+1.
// ---------------------------------------------------------------------------
module tb_clk_div_cfg_ctrl;

  localparam int SIG_RATIO = 0;
  localparam int SIG_EN    = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_READY = 3;
  localparam int SIG_ERR   = 4;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_en;
  logic       enable;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       err_clr;
  logic       cfg_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  clk_div_cfg_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst_en    (rst_en),
    .i_enable    (enable),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .i_err_clr   (err_clr),
    .o_cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] getActual(int sig);
    case (sig)
      SIG_RATIO: return div_ratio;
      SIG_EN:    return {7'd0, clk_en};
      SIG_BUSY:  return {7'd0, busy};
      SIG_READY: return {7'd0, req_ready};
      default:   return {7'd0, cfg_err};
    endcase
  endfunction

  task automatic checkOutput(input string name, input int c,
                             input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", name, c, act, exp_v);
    end
  endtask

  task automatic pushExpected(input int c, input int sig,
                              input logic [7:0] v, input string name);
    exp_t e;
    e.cyc  = c;
    e.sig  = sig;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] r,
                               input logic en, input logic rst,
                               input logic clr);
    req_valid = v;
    req_ratio = r;
    enable    = en;
    rst_en    = rst;
    err_clr   = clr;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput(sb[i].name, cyc, getActual(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values
    n = cyc;
    pushExpected(n + 1, SIG_RATIO, 8'd1, "reset_ratio");
    pushExpected(n + 1, SIG_EN,    8'd0, "reset_clk_en");
    pushExpected(n + 1, SIG_BUSY,  8'd0, "reset_busy");
    pushExpected(n + 1, SIG_READY, 8'd1, "reset_ready");
    pushExpected(n + 1, SIG_ERR,   8'd0, "reset_err");
    @(negedge clk);

    // Release reset with enable high: IDLE -> RUN on the first free edge
    n = cyc;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    pushExpected(n + 1, SIG_EN,    8'd1, "t1_clk_en_on");
    pushExpected(n + 1, SIG_RATIO, 8'd1, "t1_ratio_default");
    pushExpected(n + 1, SIG_BUSY,  8'd0, "t1_busy");
    waitUntil(n + 4);

    // Ratio change 1 -> 6 while running
    n = cyc;
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      pushExpected(n + k, SIG_EN,   8'd0, "t2_clk_en_off");
      pushExpected(n + k, SIG_BUSY, 8'd1, "t2_busy");
    end
    pushExpected(n + 1,  SIG_READY, 8'd0, "t2_ready_low");
    pushExpected(n + 5,  SIG_RATIO, 8'd1, "t2_ratio_old");
    pushExpected(n + 6,  SIG_RATIO, 8'd6, "t2_ratio_new");
    pushExpected(n + 10, SIG_EN,    8'd1, "t2_clk_en_back");
    pushExpected(n + 10, SIG_BUSY,  8'd0, "t2_busy_done");
    pushExpected(n + 10, SIG_READY, 8'd1, "t2_ready_back");
    @(negedge clk);
    applyStimulus(1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 12);

    // Same-ratio request is absorbed without disturbing the divider
    n = cyc;
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      pushExpected(n + k, SIG_EN,   8'd1, "t3_clk_en_stays");
      pushExpected(n + k, SIG_BUSY, 8'd0, "t3_busy_stays");
    end
    pushExpected(n + 1, SIG_READY, 8'd1, "t3_ready");
    pushExpected(n + 1, SIG_RATIO, 8'd6, "t3_ratio");
    @(negedge clk);
    applyStimulus(1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 4);

    // Request 3, then hold request 9 through the whole change
    n = cyc;
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    pushExpected(n + 2,  SIG_READY, 8'd0, "t4_ready_quiesce");
    pushExpected(n + 5,  SIG_READY, 8'd0, "t4_ready_load");
    pushExpected(n + 9,  SIG_READY, 8'd0, "t4_ready_settle");
    pushExpected(n + 6,  SIG_RATIO, 8'd3, "t4_ratio_3");
    pushExpected(n + 10, SIG_READY, 8'd1, "t4_ready_run");
    pushExpected(n + 10, SIG_EN,    8'd1, "t4_clk_en_run");
    pushExpected(n + 11, SIG_EN,    8'd0, "t4_held_accepted");
    pushExpected(n + 11, SIG_BUSY,  8'd1, "t4_held_busy");
    pushExpected(n + 15, SIG_RATIO, 8'd3, "t4_ratio_still_3");
    pushExpected(n + 16, SIG_RATIO, 8'd9, "t4_ratio_9");
    pushExpected(n + 19, SIG_EN,    8'd0, "t4_clk_en_settle");
    pushExpected(n + 20, SIG_EN,    8'd1, "t4_clk_en_back");
    @(negedge clk);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 11);
    applyStimulus(1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 22);

    // Enable dropped during SETTLE: change completes, ends in IDLE
    n = cyc;
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
    pushExpected(n + 6,  SIG_RATIO, 8'd4, "t5_ratio_4");
    pushExpected(n + 9,  SIG_BUSY,  8'd1, "t5_busy_settle");
    pushExpected(n + 10, SIG_EN,    8'd0, "t5_clk_en_idle");
    pushExpected(n + 10, SIG_BUSY,  8'd0, "t5_busy_done");
    pushExpected(n + 10, SIG_READY, 8'd1, "t5_ready_idle");
    pushExpected(n + 12, SIG_EN,    8'd0, "t5_stays_idle");
    pushExpected(n + 12, SIG_RATIO, 8'd4, "t5_ratio_kept");
    @(negedge clk);
    applyStimulus(1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 7);
    applyStimulus(1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
    waitUntil(n + 13);

    // Reset during LOAD restores the default ratio at once
    n = cyc;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 2);
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    pushExpected(n + 7, SIG_BUSY,  8'd1, "t5r_busy_load");
    pushExpected(n + 7, SIG_RATIO, 8'd4, "t5r_ratio_before");
    pushExpected(n + 8, SIG_RATIO, 8'd1, "t5r_ratio_default");
    pushExpected(n + 8, SIG_BUSY,  8'd0, "t5r_busy_cleared");
    pushExpected(n + 8, SIG_EN,    8'd0, "t5r_clk_en_off");
    pushExpected(n + 8, SIG_READY, 8'd1, "t5r_ready");
    pushExpected(n + 10, SIG_RATIO, 8'd1, "t5r_pending_dropped");
    pushExpected(n + 10, SIG_EN,    8'd0, "t5r_idle");
    @(negedge clk);
    applyStimulus(1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 7);
    applyStimulus(1'b0, 8'd7, 1'b1, 1'b1, 1'b0);
    waitUntil(n + 9);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    waitUntil(n + 12);

    // Ratio 0 request in IDLE, then an error clear
    n = cyc;
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef CFG_RATIO_CHECK_EN
    pushExpected(n + 1, SIG_RATIO, 8'd1, "t6_ratio_unchanged");
    pushExpected(n + 1, SIG_ERR,   8'd1, "t6_err_set");
    pushExpected(n + 2, SIG_ERR,   8'd1, "t6_err_sticky");
    pushExpected(n + 3, SIG_ERR,   8'd0, "t6_err_cleared");
`else
    pushExpected(n + 1, SIG_RATIO, 8'd0, "t6_ratio_zero");
    pushExpected(n + 1, SIG_ERR,   8'd0, "t6_err_low");
    pushExpected(n + 3, SIG_ERR,   8'd0, "t6_err_still_low");
`endif
    pushExpected(n + 1, SIG_READY, 8'd1, "t6_ready");
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    waitUntil(n + 5);

    // Request and enable together in IDLE: load first, RUN a cycle later
    n = cyc;
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    pushExpected(n + 1, SIG_RATIO, 8'd5, "t7_ratio_loaded");
    pushExpected(n + 1, SIG_EN,    8'd0, "t7_still_idle");
    pushExpected(n + 2, SIG_EN,    8'd1, "t7_run");
    @(negedge clk);
    applyStimulus(1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
    waitUntil(n + 4);

    // Request with enable low in RUN: direct load, back to IDLE
    n = cyc;
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    pushExpected(n + 1, SIG_RATIO, 8'd2, "t8_ratio_direct");
    pushExpected(n + 1, SIG_EN,    8'd0, "t8_clk_en_off");
    pushExpected(n + 1, SIG_BUSY,  8'd0, "t8_no_busy");
    pushExpected(n + 1, SIG_READY, 8'd1, "t8_ready");
    @(negedge clk);
    applyStimulus(1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    waitUntil(n + 4);
    @(negedge clk);
    #1;

    // Anything still queued was never compared
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: expected %0d at cyc %0d never compared",
               sb[i].name, sb[i].val, sb[i].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
